// File: rtl/cap_bank_update_sequencer.sv
// Sequences 7-bit tuning codes onto the shared capacitor-board code bus with setup, strobe, hold and settle phases.
// Optional feature: define CAP_SEQ_DEDUP_EN to skip the sequence when the same code is sent again.
module cap_bank_update_sequencer #(
  parameter int CODE_W     = 7,
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 5,
  parameter int HOLD_CYC   = 4,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [CODE_W-1:0] cmd_code,
  output logic              cmd_ready,
  output logic [CODE_W-1:0] code_out,
  output logic              enable_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  update_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  localparam int TMR_W = 16;
  // Timer holds (phase length - 1); the phase ends on the cycle it reads zero.
  localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(STROBE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              enable_q, enable_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              accept;
  logic              dup_hit;
  logic              start_full;

  assign cmd_ready    = (state_q == ST_IDLE) && rst_n;
  assign accept       = cmd_valid && cmd_ready;
  assign start_full   = accept && !dup_hit;
  assign code_out     = code_q;
  assign enable_out   = enable_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign update_count = count_q;

`ifdef CAP_SEQ_DEDUP_EN
  logic [CODE_W-1:0] last_code_q, last_code_d;
  logic              last_valid_q, last_valid_d;

  assign dup_hit = last_valid_q && (cmd_code == last_code_q);

  always_comb begin
    last_code_d  = last_code_q;
    last_valid_d = last_valid_q;
    if (start_full) begin
      last_code_d  = cmd_code;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_code_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_code_q  <= last_code_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    code_d   = code_q;
    enable_d = 1'b0;
    done_d   = 1'b0;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start_full) begin
          code_d  = cmd_code;
          state_d = ST_SETUP;
          timer_d = SETUP_LD;
        end else if (accept) begin
          done_d = 1'b1;
        end
      end
      ST_SETUP: begin
        if (timer_q == '0) begin
          state_d  = ST_STROBE;
          timer_d  = STROBE_LD;
          enable_d = 1'b1;
          if (count_q != '1) count_d = count_q + 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (timer_q == '0) begin
          state_d = ST_HOLD;
          timer_d = HOLD_LD;
        end else begin
          enable_d = 1'b1;
          timer_d  = timer_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (timer_q == '0) begin
          if (SETTLE_CYC == 0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            timer_d = SETTLE_LD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      code_q   <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_cap_bank_update_sequencer.sv
// Directed bench for cap_bank_update_sequencer; update_count is narrowed to 2 bits so saturation is reachable.
module tb_cap_bank_update_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [6:0] cmd_code;
  logic       cmd_ready;
  logic [6:0] code_out;
  logic       enable_out;
  logic       busy;
  logic       done;
  logic [1:0] update_count;

  int vectors = 0;
  int errors  = 0;
  logic [1:0] exp_count;

  cap_bank_update_sequencer #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_ready    (cmd_ready),
    .code_out     (code_out),
    .enable_out   (enable_out),
    .busy         (busy),
    .done         (done),
    .update_count (update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  // Follows edges 1..29 after an accept at edge 0; optionally pokes 7'h55 into STROBE.
  task automatic watch_update(input logic [6:0] exp_code, input logic [1:0] base, input bit inject);
    for (int k = 1; k <= 29; k++) begin
      tick();
      check($sformatf("enable_k%0d", k), 32'(enable_out), 32'((k >= 4 && k <= 8) ? 1 : 0));
      check($sformatf("done_k%0d", k), 32'(done), 32'((k == 29) ? 1 : 0));
      check($sformatf("busy_k%0d", k), 32'(busy), 32'((k < 29) ? 1 : 0));
      check($sformatf("code_k%0d", k), 32'(code_out), 32'(exp_code));
      check($sformatf("count_k%0d", k), 32'(update_count), 32'((k >= 4) ? sat_inc(base) : base));
      if (k == 29) check("ready_done", 32'(cmd_ready), 32'd1);
      if (inject && k == 5) begin
        cmd_valid = 1'b1;
        cmd_code  = 7'h55;
      end
      if (inject && k == 6) cmd_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = 7'h00;
    exp_count = 2'd0;

    // Test 1: reset
    repeat (3) tick();
    check("rst_code", 32'(code_out), 32'h0);
    check("rst_enable", 32'(enable_out), 32'h0);
    check("rst_count", 32'(update_count), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready_low", 32'(cmd_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(cmd_ready), 32'h1);

    // Test 2: single update of 7F
    cmd_valid = 1'b1;
    cmd_code  = 7'h7F;
    tick();
    cmd_valid = 1'b0;
    check("t2_code", 32'(code_out), 32'h7F);
    check("t2_busy", 32'(busy), 32'h1);
    check("t2_ready", 32'(cmd_ready), 32'h0);
    watch_update(7'h7F, exp_count, 1'b0);
    exp_count = sat_inc(exp_count);

    // Test 3: back-to-back 21 then 00 with valid held high
    cmd_valid = 1'b1;
    cmd_code  = 7'h21;
    tick();
    cmd_code = 7'h00;
    check("t3_code_a", 32'(code_out), 32'h21);
    watch_update(7'h21, exp_count, 1'b0);
    exp_count = sat_inc(exp_count);
    tick();
    cmd_valid = 1'b0;
    check("t3_code_b", 32'(code_out), 32'h00);
    check("t3_busy_b", 32'(busy), 32'h1);
    check("t3_done_b", 32'(done), 32'h0);
    watch_update(7'h00, exp_count, 1'b0);
    exp_count = sat_inc(exp_count);
    check("t3_count", 32'(update_count), 32'd3);

    // Test 4: 55 offered during STROBE of 21 is ignored; count already saturated
    cmd_valid = 1'b1;
    cmd_code  = 7'h21;
    tick();
    cmd_valid = 1'b0;
    watch_update(7'h21, exp_count, 1'b1);
    exp_count = sat_inc(exp_count);
    check("t4_count_sat", 32'(update_count), 32'd3);
    tick();
    check("t4_no_extra", 32'(busy), 32'h0);

    // Test 5: reset on the third STROBE cycle
    cmd_valid = 1'b1;
    cmd_code  = 7'h21;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    check("t5_strobe_on", 32'(enable_out), 32'h1);
    rst_n = 1'b0;
    tick();
    check("t5_enable", 32'(enable_out), 32'h0);
    check("t5_code", 32'(code_out), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_count", 32'(update_count), 32'h0);
    rst_n = 1'b1;
    exp_count = 2'd0;
    for (int k = 0; k < 32; k++) begin
      check($sformatf("t5_done_k%0d", k), 32'(done), 32'h0);
      check($sformatf("t5_en_k%0d", k), 32'(enable_out), 32'h0);
      tick();
    end

    // Test 6: same code twice
    cmd_valid = 1'b1;
    cmd_code  = 7'h21;
    tick();
    cmd_valid = 1'b0;
    watch_update(7'h21, exp_count, 1'b0);
    exp_count = sat_inc(exp_count);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
`ifdef CAP_SEQ_DEDUP_EN
    check("t6_dedup_done", 32'(done), 32'h1);
    check("t6_dedup_busy", 32'(busy), 32'h0);
    check("t6_dedup_count", 32'(update_count), 32'd1);
    tick();
    check("t6_dedup_done_end", 32'(done), 32'h0);
    check("t6_dedup_enable", 32'(enable_out), 32'h0);
`else
    check("t6_busy", 32'(busy), 32'h1);
    watch_update(7'h21, exp_count, 1'b0);
    check("t6_count", 32'(update_count), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
